// File: rtl/muldiv_32.sv
// muldiv_32: iterative unsigned multiply/divide unit.
// One operation in flight at a time. A three-state FSM (IDLE/CALC/DONE)
// walks WIDTH shift-add or restoring-divide steps over a 2*WIDTH accumulator.
// The write-back request is registered on the rising edge, so it is stable
// across the register file's falling-edge write.
module muldiv_32 #(
    parameter int WIDTH    = 32,
    parameter int REG_BITS = 5
) (
    input  logic                iwClk,
    input  logic                iwnRst,
    input  logic                iwStart,
    input  logic [1:0]          iwOp,
    input  logic [WIDTH-1:0]    iwOperandA,
    input  logic [WIDTH-1:0]    iwOperandB,
    input  logic [REG_BITS-1:0] iwDestReg,
    input  logic                iwFlush,
    output logic                owBusy,
    output logic                owDone,
    output logic                owWriteEnable,
    output logic [REG_BITS-1:0] owWriteReg,
    output logic [WIDTH-1:0]    owResult
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state, state_nxt;
    logic [1:0]           op;
    logic [WIDTH-1:0]     opa, opb;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;
    logic [REG_BITS-1:0]  dest;
    logic                 done, we;
    logic [WIDTH-1:0]     result;

    logic                 accept, dbz;
    logic [WIDTH:0]       mul_sum, div_rem, div_diff;
    logic [2*WIDTH-1:0]   acc_step;

    // Flush beats start, and start is only looked at while idle.
    assign accept = (state == IDLE) && iwStart && !iwFlush;
    assign dbz    = iwOp[1] && (iwOperandB == '0);

    // State register.
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = dbz ? DONE : CALC;
            CALC: begin
                if (iwFlush)                 state_nxt = IDLE;
                else if (cnt == CW'(1))      state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One iteration. Multiply: add multiplicand into the upper half when the
    // low multiplier bit is set, then shift right. Divide: shift the
    // remainder:dividend pair left, trial-subtract the divisor and keep the
    // difference only when it does not borrow. The remainder is always below
    // the divisor, so the shifted remainder fits in WIDTH+1 bits.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opa};
        div_rem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff = div_rem - {1'b0, opb};
        acc_step = acc;
        if (op[1]) begin
            if (div_diff[WIDTH]) acc_step = {div_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else                 acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            if (acc[0]) acc_step = {mul_sum, acc[WIDTH-1:1]};
            else        acc_step = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
        end
    end

    // Operand capture, iteration and registered write-back. After the last
    // step the lower half holds product-low / quotient and the upper half
    // holds product-high / remainder, so op[0] alone picks the half.
    // Divide-by-zero preloads {dividend, all-ones} and skips CALC.
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            op     <= '0;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            cnt    <= '0;
            dest   <= '0;
            done   <= 1'b0;
            we     <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            we   <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    op   <= iwOp;
                    opa  <= iwOperandA;
                    opb  <= iwOperandB;
                    dest <= iwDestReg;
                    cnt  <= CW'(WIDTH);
                    if (dbz)          acc <= {iwOperandA, {WIDTH{1'b1}}};
                    else if (iwOp[1]) acc <= {{WIDTH{1'b0}}, iwOperandA};
                    else              acc <= {{WIDTH{1'b0}}, iwOperandB};
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt - CW'(1);
                end
                DONE: if (!iwFlush) begin
                    done   <= 1'b1;
                    we     <= (dest != '0);
                    result <= op[0] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign owBusy        = (state != IDLE);
    assign owDone        = done;
    assign owWriteEnable = we;
    assign owWriteReg    = dest;
    assign owResult      = result;
endmodule

// File: doc/muldiv_32.md
Name: muldiv_32

Overview:
- Iterative unsigned multiply/divide unit for the integer pipeline.
- Takes its two operands straight from the register-file read ports (ReadData1/ReadData2).
- Produces a write-back request (enable, destination index, data) that feeds the register-file write port.
- Stalls the pipeline via owBusy while an operation is in flight; one operation at a time.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH
REG_BITS, 5, width of the destination register index

Ports:
iwClk  input  1  clock; all state updates on posedge
iwnRst  input  1  asynchronous active-low reset
iwStart  input  1  request a new operation; sampled only in IDLE
iwOp  input  2  0=MUL low, 1=MUL high, 2=DIV quotient, 3=DIV remainder (all unsigned)
iwOperandA  input  WIDTH  multiplicand / dividend (from read port 1)
iwOperandB  input  WIDTH  multiplier / divisor (from read port 2)
iwDestReg  input  REG_BITS  destination register index
iwFlush  input  1  synchronous abort of the in-flight operation
owBusy  output  1  high in CALC and DONE; the pipeline must hold issue
owDone  output  1  one-cycle completion pulse
owWriteEnable  output  1  register-file write enable; equals owDone && owWriteReg != 0
owWriteReg  output  REG_BITS  latched destination index
owResult  output  WIDTH  selected result; valid while owDone

Behaviour:
- Reset is iwnRst, asynchronous, active-low.
  - Reset drives state to IDLE and clears all outputs and internal registers to 0.
  - Reset asserted mid-operation discards the operation; no write-back occurs.
- States and transitions:
  - IDLE: iwStart=1 latches iwOp, iwOperandA, iwOperandB and iwDestReg at that edge, then goes to CALC.
  - IDLE, divide-by-zero case: if iwOp[1]=1 and iwOperandB=0, go directly to DONE.
  - CALC: runs exactly WIDTH iterations, one per cycle, using a down-counter. Go to DONE on the edge that completes the last iteration.
  - DONE: owDone=1 for exactly one cycle, then IDLE.
- Latency: start accepted at edge N gives owDone high during the cycle after edge N+WIDTH+1 (N+33 for WIDTH=32). The divide-by-zero case gives owDone after edge N+1.
- Multiply algorithm:
  - Shift-add over a 2*WIDTH product register.
  - Op 0 returns product[WIDTH-1:0]; op 1 returns product[2*WIDTH-1:WIDTH].
- Divide algorithm:
  - Restoring, one quotient bit per cycle.
  - Op 2 returns the quotient; op 3 returns the remainder.
- Divide by zero: quotient = all ones (0xFFFFFFFF); remainder = dividend.
- iwStart while owBusy=1 is ignored. The operation is not queued, and the in-flight operands are unaffected.
- iwFlush:
  - In CALC or DONE, returns to IDLE at the next edge.
  - owDone and owWriteEnable are forced to 0 in that same cycle if flush is sampled in DONE.
  - iwFlush has priority over iwStart in IDLE: start is not accepted.
- Destination register 0: owDone still pulses, but owWriteEnable stays 0. This keeps r0 hardwired to zero.
- Output holding:
  - owResult and owWriteReg hold their values after DONE until the next accepted start.
  - Consumers must qualify them with owDone.
- Timing interface:
  - The register file writes on the falling edge. owWriteEnable, owWriteReg and owResult are registered on the rising edge, so they are stable across the write edge.
  - A dependent read in the following cycle sees the new value.
- Operands are captured at start, so register-file changes during CALC have no effect.

Test Plan:
- MUL op0 with A=7, B=6, dest=3 -> owBusy high for 33 cycles; owDone pulse at start+33; owResult=42, owWriteReg=3, owWriteEnable=1.
- MUL op1 with A=B=0xFFFFFFFF -> owResult=0xFFFFFFFE. Repeat with op0 -> owResult=0x00000001.
- DIV op2 with A=100, B=7 -> owResult=14. Repeat with op3 -> owResult=2. Repeat with A=5, B=9, op2 -> 0 and op3 -> 5.
- DIV by zero with A=5, B=0: op2 -> owResult=0xFFFFFFFF; op3 -> owResult=5. In both cases owDone arrives 1 cycle after start.
- Busy/flush:
  - Second iwStart at start+10 is ignored; the result is still from the first operands.
  - iwFlush at start+15 -> IDLE next edge, no owDone, owBusy=0.
  - dest=0 -> owDone=1 with owWriteEnable=0.
- Reset: iwnRst low at start+20, asynchronously mid-cycle -> all outputs 0 immediately. After release, no write-back, and a fresh start completes normally.
